// File: rtl/dot_prod_acc_if.sv
// Sample-pair input stream, product output stream and frame configuration
// for the dot_prod_acc correlation kernel.
interface dot_prod_acc_if #(
    parameter int x_bits              = 12,
    parameter int y_bits              = 12,
    parameter int out_bits            = 24,
    parameter int length_counter_bits = 4
);
    logic [length_counter_bits:0] length_cfg;
    logic                         conj_y;

    logic                         m_axis_x_tvalid;
    logic signed [x_bits-1:0]     xi;
    logic signed [x_bits-1:0]     xq;
    logic                         m_axis_y_tvalid;
    logic signed [y_bits-1:0]     yi;
    logic signed [y_bits-1:0]     yq;
    logic                         m_axis_xy_tready;

    logic                         s_axis_product_tvalid;
    logic                         m_axis_product_tready;
    logic signed [out_bits-1:0]   i;
    logic signed [out_bits-1:0]   q;
    logic                         s_axis_product_tuser;

    // Environment side: drives samples/config and accepts results.
    modport master (
        output length_cfg, conj_y,
        output m_axis_x_tvalid, xi, xq, m_axis_y_tvalid, yi, yq,
        output m_axis_product_tready,
        input  m_axis_xy_tready,
        input  s_axis_product_tvalid, i, q, s_axis_product_tuser
    );

    // Engine side.
    modport slave (
        input  length_cfg, conj_y,
        input  m_axis_x_tvalid, xi, xq, m_axis_y_tvalid, yi, yq,
        input  m_axis_product_tready,
        output m_axis_xy_tready,
        output s_axis_product_tvalid, i, q, s_axis_product_tuser
    );
endinterface

// File: rtl/dot_prod_acc.sv
// Streaming complex dot-product: one (x, y) pair per clock, one scaled and
// saturated complex sum per frame of length_cfg pairs, full backpressure.
module dot_prod_acc #(
    parameter int x_bits              = 12,
    parameter int y_bits              = 12,
    parameter int out_bits            = 24,
    parameter int max_length          = 16,
    parameter int length_counter_bits = 4,
    parameter int out_shift           = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    dot_prod_acc_if.slave bus
);
    localparam int prod_bits = x_bits + y_bits + 1;
    localparam int sum_bits  = prod_bits + length_counter_bits + 1;
    localparam int len_bits  = length_counter_bits + 1;

    localparam logic [len_bits-1:0] max_len = len_bits'(max_length);
    localparam logic [len_bits-1:0] one_len = len_bits'(1);
    localparam logic [length_counter_bits-1:0] count_one = length_counter_bits'(1);
    localparam logic signed [sum_bits-1:0] sat_max =
        {{(sum_bits-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
    localparam logic signed [sum_bits-1:0] sat_min =
        {{(sum_bits-out_bits+1){1'b1}}, {(out_bits-1){1'b0}}};

    // Channel index 0 carries the real part, 1 the imaginary part.
    logic [length_counter_bits-1:0] count_q, count_d;
    logic [len_bits-1:0]            len_q, len_d;
    logic                           conj_q, conj_d;
    logic signed [prod_bits-1:0]    p_q [2];
    logic signed [prod_bits-1:0]    p_d [2];
    logic                           p_valid_q, p_valid_d;
    logic                           p_last_q, p_last_d;
    logic signed [sum_bits-1:0]     acc_q [2];
    logic signed [sum_bits-1:0]     acc_d [2];
    logic signed [out_bits-1:0]     out_q [2];
    logic signed [out_bits-1:0]     out_d [2];
    logic                           tvalid_q, tvalid_d;
    logic                           tuser_q, tuser_d;

    logic                           adv;
    logic                           accept;
    logic                           frame_start;
    logic                           is_last;
    logic [len_bits-1:0]            cfg_len;
    logic [len_bits-1:0]            eff_len;
    logic                           eff_conj;

    logic signed [prod_bits-1:0]    xi_e, xq_e, yi_e, yq_e;
    logic signed [prod_bits-1:0]    m_ii, m_qq, m_qi, m_iq;
    logic signed [prod_bits-1:0]    prod [2];

    logic signed [sum_bits-1:0]     sum [2];
    logic signed [sum_bits-1:0]     shifted [2];
    logic signed [out_bits-1:0]     sat_val [2];
    logic                           clamped [2];

    // Operands are widened before multiplying so the low prod_bits of each
    // product are exact regardless of operand signedness.
    always_comb begin
        xi_e = {{(prod_bits-x_bits){bus.xi[x_bits-1]}}, bus.xi};
        xq_e = {{(prod_bits-x_bits){bus.xq[x_bits-1]}}, bus.xq};
        yi_e = {{(prod_bits-y_bits){bus.yi[y_bits-1]}}, bus.yi};
        yq_e = {{(prod_bits-y_bits){bus.yq[y_bits-1]}}, bus.yq};
        m_ii = xi_e * yi_e;
        m_qq = xq_e * yq_e;
        m_qi = xq_e * yi_e;
        m_iq = xi_e * yq_e;
        prod[0] = eff_conj ? (m_ii + m_qq) : (m_ii - m_qq);
        prod[1] = eff_conj ? (m_qi - m_iq) : (m_qi + m_iq);
    end

    // Per-channel accumulate, scale and clamp.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        assign sum[gi] = acc_q[gi]
                       + {{(sum_bits-prod_bits){p_q[gi][prod_bits-1]}}, p_q[gi]};
        assign shifted[gi] = sum[gi] >>> out_shift;
        assign clamped[gi] = (shifted[gi] > sat_max) || (shifted[gi] < sat_min);
        assign sat_val[gi] = (shifted[gi] > sat_max) ? sat_max[out_bits-1:0] :
                             (shifted[gi] < sat_min) ? sat_min[out_bits-1:0] :
                                                       shifted[gi][out_bits-1:0];
    end

    always_comb begin
        adv         = !tvalid_q || bus.m_axis_product_tready;
        accept      = bus.m_axis_x_tvalid && bus.m_axis_y_tvalid && adv;
        frame_start = (count_q == '0);

        if (bus.length_cfg == '0)
            cfg_len = one_len;
        else if (bus.length_cfg > max_len)
            cfg_len = max_len;
        else
            cfg_len = bus.length_cfg;

        // Config is live on the first pair of a frame, latched thereafter.
        eff_len  = frame_start ? cfg_len : len_q;
        eff_conj = frame_start ? bus.conj_y : conj_q;
        is_last  = ({1'b0, count_q} == (eff_len - one_len));
    end

    always_comb begin
        count_d   = count_q;
        len_d     = len_q;
        conj_d    = conj_q;
        p_d       = p_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        acc_d     = acc_q;
        out_d     = out_q;
        tvalid_d  = tvalid_q;
        tuser_d   = tuser_q;

        if (adv) begin
            p_valid_d = accept;
            p_last_d  = accept && is_last;
            if (accept) begin
                p_d     = prod;
                len_d   = eff_len;
                conj_d  = eff_conj;
                count_d = is_last ? '0 : (count_q + count_one);
            end

            // A pending result is either accepted now or never existed, so
            // the output register is free whenever adv is high.
            tvalid_d = p_valid_q && p_last_q;
            if (p_valid_q) begin
                if (p_last_q) begin
                    acc_d   = '{default: '0};
                    out_d   = sat_val;
                    tuser_d = clamped[0] || clamped[1];
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            len_q     <= one_len;
            conj_q    <= 1'b0;
            p_q       <= '{default: '0};
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '{default: '0};
            out_q     <= '{default: '0};
            tvalid_q  <= 1'b0;
            tuser_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            len_q     <= len_d;
            conj_q    <= conj_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            tvalid_q  <= tvalid_d;
            tuser_q   <= tuser_d;
        end
    end

    assign bus.m_axis_xy_tready      = adv;
    assign bus.s_axis_product_tvalid = tvalid_q;
    assign bus.i                     = out_q[0];
    assign bus.q                     = out_q[1];
    assign bus.s_axis_product_tuser  = tuser_q;
endmodule
